// File: rtl/eco32f_div_pkg.sv
// Shared types and sizing helpers for the eco32f iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eco32f_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter must hold the full iteration count N = width / bpc.
  function automatic int div_cnt_width(input int width, input int bpc);
    return $clog2(width / bpc) + 1;
  endfunction

endpackage

// File: rtl/eco32f_divider_if.sv
// Operand/result handshake bundle between the EX stage and the divider.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on operands, out_valid/out_ready on results.
interface eco32f_divider_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [WIDTH-1:0] out_rem;
  logic             out_div_by_zero;
  logic             busy;

  // Pipeline side: issues operands, consumes results.
  modport master (
    output flush, in_valid, in_signed, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_div_by_zero, busy
  );

  // Divider side.
  modport slave (
    input  flush, in_valid, in_signed, in_x, in_y, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_div_by_zero, busy
  );
endinterface

// File: rtl/eco32f_div_step.sv
// Combinational block of BPC chained restoring-division steps.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register the results.
module eco32f_div_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] dvd_nxt,
  output logic [BPC-1:0]   q_bits
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [WIDTH+1:0] trial;

  // Shift one dividend bit into the partial remainder per step and subtract
  // the divisor when it fits; quotient bits come out MSB first.
  always_comb begin
    r      = rem;
    d      = dvd;
    trial  = '0;
    q_bits = '0;
    for (int i = BPC - 1; i >= 0; i--) begin
      trial = {1'b0, r, d[WIDTH-1]} - {2'b00, dvs};
      // A successful subtraction always leaves a value below the divisor,
      // so both top bits are zero exactly when the trial is non-negative.
      if (trial[WIDTH+1:WIDTH] == 2'b00) begin
        r         = trial[WIDTH-1:0];
        q_bits[i] = 1'b1;
      end else begin
        r = {r[WIDTH-2:0], d[WIDTH-1]};
      end
      d = {d[WIDTH-2:0], 1'b0};
    end
    rem_nxt = r;
    dvd_nxt = d;
  end

endmodule

// File: rtl/eco32f_divider.sv
// Iterative signed/unsigned divider producing quotient and remainder (macro ECO32F_DIV_FAST_ZERO_EN).
// Latency: WIDTH/BITS_PER_CYCLE + 2 cycles from acceptance to out_valid (2 on fast-zero bypass).
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready; flush aborts.
module eco32f_divider
  import eco32f_div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  eco32f_divider_if.slave  io
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = div_cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_e state, state_nxt;

  logic [CNT_W-1:0]          cnt;
  logic [WIDTH-1:0]          rem_q, dvd_q, dvs_q, quot_q, x_q;
  logic                      neg_quot, neg_rem, dbz_q;
  logic [WIDTH-1:0]          out_quot_q, out_rem_q;
  logic                      out_dbz_q;
  logic [WIDTH-1:0]          rem_nxt, dvd_nxt;
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic                      accept;
  logic                      fast_zero;
  logic                      x_neg, y_neg;
  logic [WIDTH-1:0]          abs_x, abs_y;

  assign accept = (state == IDLE) && io.in_valid && !io.flush;
  assign x_neg  = io.in_signed && io.in_x[WIDTH-1];
  assign y_neg  = io.in_signed && io.in_y[WIDTH-1];
  assign abs_x  = x_neg ? -io.in_x : io.in_x;
  assign abs_y  = y_neg ? -io.in_y : io.in_y;

`ifdef ECO32F_DIV_FAST_ZERO_EN
  // A zero operand has a known result, so the iterations can be skipped.
  assign fast_zero = (io.in_y == '0) || (io.in_x == '0);
`else
  assign fast_zero = 1'b0;
`endif

  eco32f_div_step #(
    .WIDTH (WIDTH),
    .BPC   (BITS_PER_CYCLE)
  ) u_step (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt),
    .q_bits  (q_bits)
  );

  // State register; reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; flush overrides every transition.
  always_comb begin
    state_nxt   = state;
    io.in_ready = 1'b0;
    io.out_valid = 1'b0;
    io.busy     = 1'b1;
    case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        io.busy     = 1'b0;
        if (io.in_valid) state_nxt = fast_zero ? FIX : CALC;
      end
      CALC: if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (io.flush) state_nxt = IDLE;
  end

  // Datapath: load magnitudes on acceptance, iterate in CALC, sign-fix into
  // the result registers in FIX. Result registers keep their value after
  // hand-off until the next FIX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      x_q        <= '0;
      neg_quot   <= 1'b0;
      neg_rem    <= 1'b0;
      dbz_q      <= 1'b0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= CNT_INIT;
            rem_q    <= '0;
            dvd_q    <= abs_x;
            dvs_q    <= abs_y;
            quot_q   <= '0;
            x_q      <= io.in_x;
            neg_quot <= x_neg ^ y_neg;
            neg_rem  <= x_neg;
            dbz_q    <= (io.in_y == '0);
          end
        end
        CALC: begin
          cnt    <= cnt - 1'b1;
          rem_q  <= rem_nxt;
          dvd_q  <= dvd_nxt;
          quot_q <= {quot_q[WIDTH-BITS_PER_CYCLE-1:0], q_bits};
        end
        FIX: begin
          // Divide-by-zero returns all ones and the untouched dividend.
          out_quot_q <= dbz_q ? '1  : (neg_quot ? -quot_q : quot_q);
          out_rem_q  <= dbz_q ? x_q : (neg_rem  ? -rem_q  : rem_q);
          out_dbz_q  <= dbz_q;
        end
        default: ;
      endcase
    end
  end

  assign io.out_quot        = out_quot_q;
  assign io.out_rem         = out_rem_q;
  assign io.out_div_by_zero = out_dbz_q;

endmodule

// File: tb/tb_eco32f_divider.sv
// Self-checking bench for eco32f_divider against a plain-arithmetic model.
// Latency: checks acceptance-to-out_valid latency on every operation.
// Backpressure: exercises random and held-off out_ready, flush and reset.
module tb_eco32f_divider;

  localparam int WIDTH = 32;
  localparam int BPC   = 4;
  localparam int N     = WIDTH / BPC;
  localparam int LAT   = N + 2;
  localparam int FL_AT = (N > 10) ? 10 : N - 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  eco32f_divider_if #(.WIDTH(WIDTH)) dif ();

  eco32f_divider #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // C-semantics reference: truncating division, remainder takes dividend sign.
  function automatic void model(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y);
`ifdef ECO32F_DIV_FAST_ZERO_EN
    if (x == 32'd0 || y == 32'd0) return 2;
`endif
    return LAT;
  endfunction

  // Present operands at a negedge once in_ready is seen; returns after the accept edge.
  task automatic start_op(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    int w = 0;
    while (!dif.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", w < 100, 1);
    dif.in_signed = sgn;
    dif.in_x      = x;
    dif.in_y      = y;
    dif.in_valid  = 1'b1;
    @(negedge clk);
    dif.in_valid  = 1'b0;
    dif.in_x      = $urandom;
    dif.in_y      = $urandom;
    dif.in_signed = 1'($urandom_range(0, 1));
  endtask

  // Called one cycle after acceptance; counts cycles until out_valid.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!dif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] x,
                        input logic [31:0] y, input int stall, input bit watch_hold);
    logic [31:0] eq, er;
    int lat;
    model(sgn, x, y, eq, er);
    start_op(sgn, x, y);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_latency(x, y));
    check({tag, "_quot"}, dif.out_quot, eq);
    check({tag, "_rem"}, dif.out_rem, er);
    check({tag, "_dbz"}, dif.out_div_by_zero, (y == 32'd0));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (watch_hold) begin
        check({tag, "_hold_vld"}, dif.out_valid, 1);
        check({tag, "_hold_rdy"}, dif.in_ready, 0);
        check({tag, "_hold_quot"}, dif.out_quot, eq);
        check({tag, "_hold_rem"}, dif.out_rem, er);
      end
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    check({tag, "_post_vld"}, dif.out_valid, 0);
    check({tag, "_post_busy"}, dif.busy, 0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        sgn;
    int          seen, lat;

    dif.flush     = 1'b0;
    dif.in_valid  = 1'b0;
    dif.in_signed = 1'b0;
    dif.in_x      = '0;
    dif.in_y      = '0;
    dif.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", dif.in_ready, 1);
    check("rst_out_valid", dif.out_valid, 0);
    check("rst_busy", dif.busy, 0);
    check("rst_dbz", dif.out_div_by_zero, 0);
    check("rst_quot", dif.out_quot, 0);
    check("rst_rem", dif.out_rem, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 0, 1'b0);
    run_op("s-7_2", 1'b1, -32'sd7, 32'd2, 0, 1'b0);
    run_op("s7_-2", 1'b1, 32'd7, -32'sd2, 0, 1'b0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("u_zero_x", 1'b0, 32'd0, 32'd5, 0, 1'b0);
    run_op("bp", 1'b0, 32'd100, 32'd7, 5, 1'b1);
    run_op("u_dbz", 1'b0, 32'h1234, 32'd0, 0, 1'b0);
    run_op("s_dbz", 1'b1, 32'h1234, 32'd0, 0, 1'b0);

    // Flush mid-CALC with a competing in_valid: must go idle without accepting.
    start_op(1'b0, 32'hFFFF_0000, 32'd3);
    repeat (FL_AT - 1) @(negedge clk);
    dif.flush    = 1'b1;
    dif.in_valid = 1'b1;
    dif.in_x     = 32'd5;
    dif.in_y     = 32'd1;
    @(negedge clk);
    dif.flush    = 1'b0;
    dif.in_valid = 1'b0;
    check("flush_busy", dif.busy, 0);
    check("flush_in_ready", dif.in_ready, 1);
    check("flush_out_valid", dif.out_valid, 0);
    seen = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (dif.out_valid) seen++;
    end
    check("flush_no_result", seen, 0);
    run_op("after_flush", 1'b0, 32'd9, 32'd3, 0, 1'b0);

    // Flush while results are waiting drops out_valid.
    start_op(1'b0, 32'd50, 32'd6);
    wait_done(lat);
    check("flushdone_lat", lat, LAT);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flushdone_vld", dif.out_valid, 0);
    check("flushdone_busy", dif.busy, 0);

    // Reset mid-CALC after a divide-by-zero left non-zero results behind.
    run_op("pre_rst_dbz", 1'b1, 32'hDEAD_BEEF, 32'd0, 0, 1'b0);
    start_op(1'b0, 32'd1000, 32'd7);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", dif.in_ready, 1);
    check("mrst_out_valid", dif.out_valid, 0);
    check("mrst_busy", dif.busy, 0);
    check("mrst_dbz", dif.out_div_by_zero, 0);
    check("mrst_quot", dif.out_quot, 0);
    check("mrst_rem", dif.out_rem, 0);
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst", 1'b1, -32'sd100, 32'd9, 0, 1'b0);

    // Random operands, modes and consumer stalls.
    for (int k = 0; k < 1000; k++) begin
      x   = $urandom;
      y   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: x = 32'd0;
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = $urandom_range(1, 15);
        4: y = 32'($urandom_range(1, 65535));
        5: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rnd", sgn, x, y, $urandom_range(0, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eco32f_divider.md
# eco32f_divider

Parametrised iterative integer divider, successor to the serial divider embedded in the eco32f ALU. Computes quotient and remainder together for signed or unsigned operands of configurable width, retiring a configurable number of quotient bits per cycle. Sits beside the ALU in EX and connects through valid/ready handshakes, so the pipeline stalls on `busy` instead of re-deriving divider state from stage stalls. A flush input kills an in-flight operation on exceptions and branches.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 8.
- `BITS_PER_CYCLE`, 1, quotient bits per iteration; 1, 2 or 4; must divide `WIDTH`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  abort any operation; wins over all other inputs.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  divider can accept (state IDLE).
- `in_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `in_x`  in  WIDTH  dividend.
- `in_y`  in  WIDTH  divisor.
- `out_valid`  out  1  results present (state DONE).
- `out_ready`  in  1  consumer takes results.
- `out_quot`  out  WIDTH  quotient.
- `out_rem`  out  WIDTH  remainder.
- `out_div_by_zero`  out  1  divisor was zero.
- `busy`  out  1  state ≠ IDLE.

## Operation
- N = `WIDTH`/`BITS_PER_CYCLE` iterations.
- States: IDLE → CALC → FIX → DONE → IDLE.
- IDLE: `in_ready`=1. `in_valid` with no `flush`: latch sign flags, load |x| and |y| (magnitudes when `in_signed`, raw otherwise), remainder = 0, counter = N → CALC.
- CALC: restoring division, `BITS_PER_CYCLE` bits per cycle: per bit, trial = {rem, next dividend MSB} − divisor (width `WIDTH`+1); trial non-negative → rem = trial, quotient bit 1; else shift, quotient bit 0. Counter decrements; at 1 → FIX.
- FIX: quotient negated iff `in_signed` and x, y signs differ; remainder negated iff `in_signed` and x negative (remainder takes dividend sign, C semantics). Results registered → DONE.
- Divide by zero: `out_div_by_zero`=1, `out_quot` = all ones, `out_rem` = original `in_x`, for signed and unsigned.
- Signed overflow (−2^(WIDTH−1) / −1): `out_quot` = −2^(WIDTH−1), `out_rem` = 0, `out_div_by_zero` = 0.
- DONE: `out_valid`=1; outputs hold until `out_valid & out_ready` → IDLE. No acceptance in the same cycle as hand-off.
- `flush` in any state: IDLE next cycle, `out_valid` drops, no acceptance that cycle, results discarded.
- Operand inputs are sampled only at acceptance; later changes ignored.

## Timing
- Reset (`rst`=0 at an edge): state IDLE; `in_ready`=1; `out_valid`, `busy`, `out_div_by_zero`=0; `out_quot`, `out_rem`=0. Reset mid-operation behaves as flush.
- Acceptance in cycle t: CALC in t+1..t+N, FIX in t+N+1, `out_valid` from t+N+2. WIDTH=32, BPC=1: 34; BPC=4: 10.
- `busy` rises cycle t+1; falls the cycle after hand-off or flush.
- `out_ready` held high in DONE: one cycle of `out_valid`; next acceptance earliest one cycle later.
- Throughput: one operation per N+3 cycles.

## Configuration
- `ECO32F_DIV_FAST_ZERO_EN` defined: at acceptance, divisor == 0 or dividend == 0 bypasses CALC (IDLE → FIX), `out_valid` at t+2, results as specified above.
- Undefined: every operation takes N iterations; results bit-identical, only latency differs.

## Structure
- Package `eco32f_div_pkg`: state enum (IDLE, CALC, FIX, DONE), state-width constant, iteration-counter width function (clog2(N)+1).
- Sub-module `eco32f_div_step`: combinational, `BITS_PER_CYCLE` chained restoring steps; inputs rem, dividend shift window, divisor; outputs next rem, next dividend, quotient bits. Instantiated once in the top-level FSM/datapath.

## Test plan
- Unsigned, WIDTH=32, BPC=1: x=100, y=7 → quot 14, rem 2, `out_valid` exactly 34 cycles after acceptance.
- Signed: x=−7, y=2 → quot −3, rem −1; x=7, y=−2 → quot −3, rem 1; x=0x80000000, y=−1 → quot 0x80000000, rem 0.
- Divide by zero: x=0x1234, y=0, signed and unsigned → quot 0xFFFFFFFF, rem 0x1234, flag 1; latency 34 without macro, 2 with `ECO32F_DIV_FAST_ZERO_EN`.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0; `out_ready`=1 → IDLE next cycle.
- Flush at CALC cycle 10, `in_valid` high same cycle → IDLE next cycle, no `out_valid`, next op x=9, y=3 → quot 3, rem 0.
- BPC=4, 1000 random signed/unsigned pairs vs reference model, random `out_ready`, latency 10; `rst`=0 mid-CALC → all outputs at reset values next cycle.
